// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and next-PC select encoding for the PC sequencer slice.
package pc_sequencer_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_STEP      = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam int unsigned DEF_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        SEL_SEQ   = 2'd0,
        SEL_JUMP  = 2'd1,
        SEL_RET   = 2'd2,
        SEL_FLUSH = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect inputs and PC/RAS status outputs of the PC sequencer.
// Level-sampled controls: every i_* value is taken at each rising clk edge; no handshake.
interface pc_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              i_halt;
    logic              i_stall;
    logic              i_flush;
    logic [DATA_W-1:0] i_flush_addr;
    logic              i_jump;
    logic              i_call;
    logic              i_ret;
    logic [DATA_W-1:0] i_jump_address;
    logic [DATA_W-1:0] o_pc;
    logic              o_ras_empty;
    logic              o_ras_full;
    logic              o_ras_underflow;

    modport master (
        output i_halt, i_stall, i_flush, i_flush_addr, i_jump, i_call, i_ret, i_jump_address,
        input  o_pc, o_ras_empty, o_ras_full, o_ras_underflow
    );

    modport slave (
        input  i_halt, i_stall, i_flush, i_flush_addr, i_jump, i_call, i_ret, i_jump_address,
        output o_pc, o_ras_empty, o_ras_full, o_ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              replace_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [DATA_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, wr_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, full_q;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_idx = ptr_q;
        if (push_i) begin
            ptr_d  = ptr_q + PTR_W'(1);
            wr_idx = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_MAX);
        end
    end

    // Entry storage carries no reset; a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_i || replace_i) mem_q[wr_idx] <= data_i;
    end

    assign top_o   = mem_q[ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential step, jump/call/ret redirects, late-stage flush.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter int unsigned       STEP      = DEF_STEP,
    parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(DEF_RESET_VEC),
    parameter int unsigned       RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic           clk,
    input  logic           i_reset,
    pc_sequencer_if.slave  bus
);
    logic [DATA_W-1:0] pc_q, pc_d, pc_plus, ras_top;
    logic              uf_q, uf_d;
    logic              update, push, pop, replace, ras_empty, ras_full;
    pc_sel_e           sel;

    // A flush overrides a stall but never a halt.
    assign update  = !bus.i_halt && (!bus.i_stall || bus.i_flush);
    assign pc_plus = pc_q + DATA_W'(STEP);

    always_comb begin
        sel = SEL_SEQ;
        if (bus.i_flush)                   sel = SEL_FLUSH;
        else if (bus.i_ret)                sel = SEL_RET;
        else if (bus.i_call || bus.i_jump) sel = SEL_JUMP;
    end

    always_comb begin
        pc_d    = pc_q;
        uf_d    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        if (update) begin
            case (sel)
                SEL_FLUSH: pc_d = bus.i_flush_addr;
                SEL_JUMP: begin
                    pc_d = bus.i_jump_address;
                    push = bus.i_call;
                end
                SEL_RET: begin
                    if (ras_empty) begin
                        pc_d = bus.i_jump_address;
                        uf_d = 1'b1;
                        push = bus.i_call;
                    end else begin
                        pc_d    = ras_top;
                        replace = bus.i_call;
                        pop     = !bus.i_call;
                    end
                end
                default: pc_d = pc_plus;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q <= RESET_VEC;
            uf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
        end
    end

    pc_ras #(
        .DATA_W    (DATA_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .i_reset   (i_reset),
        .push_i    (push),
        .pop_i     (pop),
        .replace_i (replace),
        .data_i    (pc_plus),
        .top_o     (ras_top),
        .empty_o   (ras_empty),
        .full_o    (ras_full)
    );

    assign bus.o_pc            = pc_q;
    assign bus.o_ras_empty     = ras_empty;
    assign bus.o_ras_full      = ras_full;
    assign bus.o_ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus reset and wrap sequences.
module tb_pc_sequencer;

    typedef struct {
        logic        halt, stall, flush;
        logic [31:0] faddr;
        logic        jump, call, ret;
        logic [31:0] jaddr;
        logic [31:0] exp_pc;
        logic        exp_empty, exp_full, exp_uf;
    } vec_t;

    logic clk;
    logic i_reset;
    int   checks;
    int   errors;
    vec_t vecs[$];
    logic [31:0] exp_q[$];

    pc_sequencer_if #(.DATA_W(32)) bus ();
    pc_sequencer_if #(.DATA_W(32)) wbus ();

    pc_sequencer #(.DATA_W(32), .STEP(4), .RESET_VEC(32'h0), .RAS_DEPTH(4)) u_dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    pc_sequencer #(.DATA_W(32), .STEP(4), .RESET_VEC(32'hFFFF_FFFC), .RAS_DEPTH(4)) u_wrap (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (wbus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic drive(input logic h, s, f, input logic [31:0] fa,
                         input logic j, c, r, input logic [31:0] ja);
        bus.i_halt         = h;
        bus.i_stall        = s;
        bus.i_flush        = f;
        bus.i_flush_addr   = fa;
        bus.i_jump         = j;
        bus.i_call         = c;
        bus.i_ret          = r;
        bus.i_jump_address = ja;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic h, s, f, input logic [31:0] fa,
                       input logic j, c, r, input logic [31:0] ja,
                       input logic [31:0] pc, input logic e, fu, uf);
        vec_t v;
        v.halt = h; v.stall = s; v.flush = f; v.faddr = fa;
        v.jump = j; v.call = c; v.ret = r; v.jaddr = ja;
        v.exp_pc = pc; v.exp_empty = e; v.exp_full = fu; v.exp_uf = uf;
        vecs.push_back(v);
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e, fu, uf);
        chk({tag, " empty"}, {31'b0, bus.o_ras_empty}, {31'b0, e});
        chk({tag, " full"}, {31'b0, bus.o_ras_full}, {31'b0, fu});
        chk({tag, " underflow"}, {31'b0, bus.o_ras_underflow}, {31'b0, uf});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wbus.i_halt = 1'b0; wbus.i_stall = 1'b0; wbus.i_flush = 1'b0; wbus.i_flush_addr = '0;
        wbus.i_jump = 1'b0; wbus.i_call = 1'b0; wbus.i_ret = 1'b0; wbus.i_jump_address = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        i_reset = 1'b0;

        //   h s f faddr      j c r jaddr       exp_pc      e f u
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'h4,      1, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'h8,      1, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'hC,      1, 0, 0);
        add(1, 0, 0, 0,        0, 0, 0, 0,        32'hC,      1, 0, 0);
        add(1, 0, 0, 0,        0, 0, 0, 0,        32'hC,      1, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'h10,     1, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h100,  32'h100,    0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'h104,    0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'h108,    0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h14,     1, 0, 0);
        add(0, 0, 1, 0,        0, 0, 0, 0,        32'h0,      1, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h100,  32'h100,    0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h200,  32'h200,    0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h300,  32'h300,    0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h400,  32'h400,    0, 1, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h500,  32'h500,    0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h404,    0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h304,    0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h204,    0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h104,    1, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 32'h600,  32'h600,    1, 0, 1);
        add(0, 0, 0, 0,        0, 0, 0, 0,        32'h604,    1, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'hA00,  32'hA00,    0, 0, 0);
        add(0, 1, 0, 0,        0, 0, 1, 32'h777,  32'hA00,    0, 0, 0);
        add(0, 1, 1, 32'h80,   0, 1, 0, 32'h999,  32'h80,     0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h608,    1, 0, 0);
        add(0, 0, 1, 32'h4C,   0, 0, 0, 0,        32'h4C,     1, 0, 0);
        add(0, 0, 0, 0,        0, 1, 0, 32'h20,   32'h20,     0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 1, 32'h300,  32'h50,     0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h24,     1, 0, 0);
        add(0, 0, 0, 0,        0, 1, 1, 32'h700,  32'h700,    0, 0, 1);
        add(0, 0, 0, 0,        0, 0, 1, 0,        32'h28,     1, 0, 0);
        add(0, 0, 0, 0,        1, 0, 0, 32'h1000, 32'h1000,   1, 0, 0);
        add(1, 0, 1, 32'h5,    0, 0, 0, 0,        32'h1000,   1, 0, 0);
        add(1, 0, 0, 0,        0, 0, 1, 32'h9,    32'h1000,   1, 0, 0);

        // reset state
        tick();
        tick();
        chk("reset pc", bus.o_pc, 32'h0);
        chk_flags("reset", 1'b1, 1'b0, 1'b0);
        chk("reset wrap pc", wbus.o_pc, 32'hFFFF_FFFC);
        i_reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].halt, vecs[i].stall, vecs[i].flush, vecs[i].faddr,
                  vecs[i].jump, vecs[i].call, vecs[i].ret, vecs[i].jaddr);
            exp_q.push_back(vecs[i].exp_pc);
            tick();
            chk($sformatf("v%0d pc", i), bus.o_pc, exp_q.pop_front());
            chk_flags($sformatf("v%0d", i), vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_uf);
            if (i == 0) chk("wrap pc", wbus.o_pc, 32'h0);
        end

        // two pushes, then asynchronous reset between edges
        drive(0, 0, 0, 0, 0, 1, 0, 32'h200);
        tick();
        chk("push1 pc", bus.o_pc, 32'h200);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h300);
        tick();
        chk("push2 pc", bus.o_pc, 32'h300);
        chk_flags("push2", 1'b0, 1'b0, 1'b0);
        #3;
        i_reset = 1'b0;
        #1;
        chk("async reset pc", bus.o_pc, 32'h0);
        chk_flags("async reset", 1'b1, 1'b0, 1'b0);
        chk("async reset wrap pc", wbus.o_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("held reset pc", bus.o_pc, 32'h0);
        i_reset = 1'b1;
        tick();
        chk("post reset pc", bus.o_pc, 32'h4);
        chk("post reset wrap pc", wbus.o_pc, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h44);
        tick();
        chk("discarded ras pc", bus.o_pc, 32'h44);
        chk_flags("discarded ras", 1'b1, 1'b0, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("underflow clears", {31'b0, bus.o_ras_underflow}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, PC and address width in bits.
REQ-002 Parameter STEP, default 4, sequential increment in bytes.
REQ-003 Parameter RESET_VEC, default 0, PC value after reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >= 2.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  reset; asynchronous, active-low.
REQ-007 i_halt  input  1  freezes PC and RAS completely.
REQ-008 i_stall  input  1  hazard stall; freezes PC and RAS except for flush.
REQ-009 i_flush  input  1  redirect from a later stage (mispredict/exception).
REQ-010 i_flush_addr  input  DATA_W  flush target.
REQ-011 i_jump  input  1  unconditional redirect to i_jump_address.
REQ-012 i_call  input  1  redirect to i_jump_address and push o_pc+STEP.
REQ-013 i_ret  input  1  redirect to RAS top and pop.
REQ-014 i_jump_address  input  DATA_W  jump/call target; also the ret fallback target.
REQ-015 o_pc  output  DATA_W  current PC (registered).
REQ-016 o_ras_empty  output  1  RAS holds zero entries (registered).
REQ-017 o_ras_full  output  1  RAS holds RAS_DEPTH entries (registered).
REQ-018 o_ras_underflow  output  1  one-cycle pulse: ret was taken with RAS empty.

Function
REQ-019 An update cycle is a cycle with !i_halt and (!i_stall or i_flush); in all other cycles o_pc, the RAS and its count SHALL hold.
REQ-020 Next-PC priority in an update cycle SHALL be: i_flush -> i_flush_addr; else i_ret -> RAS top; else i_call or i_jump -> i_jump_address; else o_pc+STEP.
REQ-021 o_pc+STEP SHALL be computed modulo 2^DATA_W (0xFFFFFFFC+4 wraps to 0x00000000).
REQ-022 A flush SHALL leave the RAS unchanged, even if i_call/i_ret are also asserted.
REQ-023 A call (no flush, no ret) SHALL push o_pc+STEP; count increments, saturating at RAS_DEPTH.
REQ-024 A push when full SHALL overwrite the oldest entry (circular top pointer); count stays RAS_DEPTH.
REQ-025 A ret (no flush) with count > 0 SHALL load the top entry into o_pc and decrement the count.
REQ-026 A ret with count == 0 SHALL load i_jump_address, leave the RAS unchanged, and assert o_ras_underflow for exactly the next cycle.
REQ-027 Simultaneous i_call and i_ret (no flush) SHALL load the RAS top into o_pc and overwrite that top entry with o_pc+STEP, leaving count unchanged; if empty, behaviour follows REQ-026 plus a normal push.
REQ-028 Redirect latency SHALL be one cycle: the controls sampled at edge N are reflected in o_pc after edge N.
REQ-029 o_ras_empty and o_ras_full SHALL reflect the count after each edge.
REQ-030 In a non-update cycle, o_ras_underflow SHALL be 0.

Reset
REQ-031 While i_reset is 0: o_pc = RESET_VEC, RAS count = 0, top pointer = 0, o_ras_empty = 1, o_ras_full = 0, o_ras_underflow = 0; entry contents are don't-care.
REQ-032 Reset asserted mid-operation SHALL take effect immediately without waiting for clk and SHALL discard all RAS contents.
REQ-033 After reset deasserts, the first rising edge SHALL be a normal update cycle.

Structure
REQ-034 A shared package SHALL hold the DATA_W/STEP/RESET_VEC defaults and the next-PC-select enumeration (SEQ, JUMP, RET, FLUSH).
REQ-035 The RAS SHALL be a sub-module pc_ras, with push/pop/replace inputs, top, empty, full outputs, and parametrised by DATA_W and RAS_DEPTH.

Verification
REQ-036 Reset, then 3 idle cycles -> o_pc = 0, 4, 8, 12; i_halt for 2 cycles -> o_pc holds 12.
REQ-037 At o_pc = 0x10, call to 0x100; then 2 cycles; then ret -> o_pc = 0x100, 0x104, 0x108, then 0x14; o_ras_empty returns to 1.
REQ-038 With RAS_DEPTH = 4, perform 5 nested calls from 0x0, 0x100, 0x200, 0x300, 0x400, then 5 rets -> returns 0x404, 0x304, 0x204, 0x104, then the fifth ret uses i_jump_address with an underflow pulse.
REQ-039 With i_stall = 1, assert i_flush with i_flush_addr = 0x80 and i_call = 1 -> o_pc = 0x80 next cycle, RAS count unchanged.
REQ-040 At o_pc = 0x20 with RAS top 0x50, assert i_call and i_ret together -> o_pc = 0x50, RAS top = 0x24, count unchanged.
REQ-041 Assert i_reset mid-cycle after 2 pushes -> o_pc = 0 asynchronously, o_ras_empty = 1; PC wrap: RESET_VEC = 0xFFFFFFFC -> next o_pc = 0.
